// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched
// Arbitrates the single regfile write port between the ALU and LSU writeback
// sources and keeps the per-register busy scoreboard used by decode for
// RAW/WAW hazard stalls.
module regfile_wb_sched #(
    parameter int XLEN = 64,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rs1,
    input  logic [AW-1:0]        issue_rs2,
    input  logic [AW-1:0]        issue_rd,
    input  logic                 issue_wr,
    output logic                 issue_stall,
    input  logic                 alu_valid,
    input  logic [AW-1:0]        alu_rd,
    input  logic [XLEN-1:0]      alu_data,
    output logic                 alu_ready,
    input  logic                 lsu_valid,
    input  logic [AW-1:0]        lsu_rd,
    input  logic [XLEN-1:0]      lsu_data,
    output logic                 lsu_ready,
    output logic                 rd_write,
    output logic [AW-1:0]        rd,
    output logic [XLEN-1:0]      rd_data,
    output logic [(2**AW)-1:0]   busy,
    output logic                 wb_err
);

    localparam int NREG = 2**AW;

    // Round-robin memory: which source won the most recent grant.
    localparam logic [0:0] SRC_ALU = 1'b0;
    localparam logic [0:0] SRC_LSU = 1'b1;

    logic [0:0]      rr_last;
    logic            alu_gnt;
    logic            lsu_gnt;
    logic            any_gnt;
    logic [AW-1:0]   win_rd;
    logic [XLEN-1:0] win_data;
    logic            accept;
    logic [NREG-1:0] busy_set;
    logic [NREG-1:0] busy_clr;
    logic [NREG-1:0] busy_next;

    // Hazard detection looks only at the registered scoreboard (no bypass).
    always_comb begin
        issue_stall = issue_valid &
                      (busy[issue_rs1] | busy[issue_rs2] | (issue_wr & busy[issue_rd]));
        accept      = issue_valid & ~issue_stall;
    end

    // Writeback arbitration: sole requester wins, on conflict the source
    // that did not win last time is granted.
    always_comb begin
        alu_gnt   = alu_valid & (~lsu_valid | (rr_last == SRC_LSU));
        lsu_gnt   = lsu_valid & ~alu_gnt;
        any_gnt   = alu_gnt | lsu_gnt;
        alu_ready = alu_gnt;
        lsu_ready = lsu_gnt;
        win_rd    = lsu_gnt ? lsu_rd   : alu_rd;
        win_data  = lsu_gnt ? lsu_data : alu_data;
    end

    // Scoreboard next state: clear on regfile consume, set on accepted issue;
    // a set on the same edge as a clear of the same register takes priority.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (rd_write) begin
            busy_clr[rd] = 1'b1;
        end
        if (accept && issue_wr && (issue_rd != '0)) begin
            busy_set[issue_rd] = 1'b1;
        end
        busy_next    = (busy & ~busy_clr) | busy_set;
        busy_next[0] = 1'b0;
    end

    // Registered write port toward the regfile; rd/rd_data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_write <= 1'b0;
            rd       <= '0;
            rd_data  <= '0;
        end else if (any_gnt) begin
            rd_write <= (win_rd != '0);
            rd       <= win_rd;
            rd_data  <= win_data;
        end else begin
            rd_write <= 1'b0;
        end
    end

    // Arbitration history; reset to LSU so the ALU wins the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= SRC_LSU;
        end else if (any_gnt) begin
            rr_last <= lsu_gnt ? SRC_LSU : SRC_ALU;
        end
    end

    // Busy scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Sticky error: a writeback granted to a register nobody marked busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_err <= 1'b0;
        end else if (any_gnt && (win_rd != '0) && !busy[win_rd]) begin
            wb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Testbench for regfile_wb_sched: directed stimulus; expected regfile writes
// are queued when a grant is issued and popped by a monitor whenever the DUT
// drives rd_write.
module tb_regfile_wb_sched;

    localparam int XLEN = 64;
    localparam int AW   = 5;

    logic            clk;
    logic            rst_n;
    logic            issue_valid;
    logic [AW-1:0]   issue_rs1;
    logic [AW-1:0]   issue_rs2;
    logic [AW-1:0]   issue_rd;
    logic            issue_wr;
    logic            issue_stall;
    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            lsu_valid;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            lsu_ready;
    logic            rd_write;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] rd_data;
    logic [31:0]     busy;
    logic            wb_err;

    typedef struct {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    regfile_wb_sched #(.XLEN(XLEN), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_stall(issue_stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .rd_write(rd_write), .rd(rd), .rd_data(rd_data), .busy(busy), .wb_err(wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [AW-1:0] r, input logic [XLEN-1:0] d);
        wr_t e;
        e.rd   = r;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic do_issue(input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                            input logic [AW-1:0] d, input logic wr);
        issue_valid = 1'b1;
        issue_rs1   = s1;
        issue_rs2   = s2;
        issue_rd    = d;
        issue_wr    = wr;
    endtask

    // Monitor: every regfile write presented must match the oldest expectation.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n === 1'b1 && rd_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got rd=%0d data=%0h expected no write", rd, rd_data);
            end else begin
                e = exp_q.pop_front();
                chk("wb_rd", 64'(rd), 64'(e.rd));
                chk("wb_data", rd_data, e.data);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ai;
        int li;
        rst_n = 1'b0;
        issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0; issue_wr = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_rd_write", 64'(rd_write), 64'd0);
        chk("rst_rd", 64'(rd), 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wb_err", 64'(wb_err), 64'd0);
        rst_n = 1'b1;

        // T1: reset asserted while a write is on the port
        @(negedge clk); do_issue(0, 0, 3, 1'b1);
        #1 chk("t1_issue_stall", 64'(issue_stall), 64'd0);
        @(negedge clk); issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 3; alu_data = 64'hAA;
        #1 chk("t1_alu_ready", 64'(alu_ready), 64'd1);
        chk("t1_busy3", 64'(busy[3]), 64'd1);
        @(posedge clk); #1;
        chk("t1_rd_write_pre", 64'(rd_write), 64'd1);
        rst_n = 1'b0; alu_valid = 1'b0;
        #1;
        chk("t1_async_rd_write", 64'(rd_write), 64'd0);
        chk("t1_async_rd", 64'(rd), 64'd0);
        chk("t1_async_rd_data", rd_data, 64'd0);
        chk("t1_async_busy", 64'(busy), 64'd0);
        chk("t1_async_wb_err", 64'(wb_err), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // First conflict after reset goes to the ALU, then LSU
        @(negedge clk); do_issue(0, 0, 3, 1'b1);
        @(negedge clk); do_issue(0, 0, 4, 1'b1);
        @(negedge clk); issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 3; alu_data = 64'h3333;
        lsu_valid = 1'b1; lsu_rd = 4; lsu_data = 64'h4444;
        #1 chk("t1_conf_alu_ready", 64'(alu_ready), 64'd1);
        chk("t1_conf_lsu_ready", 64'(lsu_ready), 64'd0);
        push(3, 64'h3333);
        @(negedge clk); alu_valid = 1'b0;
        #1 chk("t1_lsu_ready", 64'(lsu_ready), 64'd1);
        push(4, 64'h4444);
        @(negedge clk); lsu_valid = 1'b0;

        // T3: sustained conflict alternates starting with ALU (LSU won last)
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); do_issue(0, 0, AW'(10 + i), 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); do_issue(0, 0, AW'(20 + i), 1'b1);
        end
        @(negedge clk); issue_valid = 1'b0;
        ai = 0; li = 0;
        for (int k = 0; k < 6; k++) begin
            alu_valid = (ai < 3); alu_rd = AW'(10 + ai); alu_data = 64'hA0 + 64'(ai);
            lsu_valid = (li < 3); lsu_rd = AW'(20 + li); lsu_data = 64'hB0 + 64'(li);
            #1;
            chk("t3_one_winner", 64'(alu_ready & lsu_ready), 64'd0);
            chk("t3_alu_ready", 64'(alu_ready), (k % 2 == 0) ? 64'd1 : 64'd0);
            if (k % 2 == 0) begin
                push(AW'(10 + ai), 64'hA0 + 64'(ai)); ai++;
            end else begin
                push(AW'(20 + li), 64'hB0 + 64'(li)); li++;
            end
            @(negedge clk);
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3_busy_drained", 64'(busy), 64'd0);
        chk("t3_wb_err", 64'(wb_err), 64'd0);

        // T2: RAW stall released two cycles after the ALU grant
        do_issue(0, 0, 5, 1'b1);
        #1 chk("t2_first_stall", 64'(issue_stall), 64'd0);
        @(negedge clk); do_issue(5, 0, 6, 1'b1);
        #1 chk("t2_stall_a", 64'(issue_stall), 64'd1);
        @(negedge clk);
        #1 chk("t2_stall_b", 64'(issue_stall), 64'd1);
        @(negedge clk); alu_valid = 1'b1; alu_rd = 5; alu_data = 64'h1234;
        #1 chk("t2_alu_ready", 64'(alu_ready), 64'd1);
        chk("t2_stall_n", 64'(issue_stall), 64'd1);
        push(5, 64'h1234);
        @(negedge clk); alu_valid = 1'b0;
        #1 chk("t2_stall_n1", 64'(issue_stall), 64'd1);
        chk("t2_rd_write_n1", 64'(rd_write), 64'd1);
        @(negedge clk);
        #1 chk("t2_stall_n2", 64'(issue_stall), 64'd0);
        @(negedge clk); issue_valid = 1'b0;
        #1 chk("t2_busy6", 64'(busy[6]), 64'd1);
        chk("t2_busy5", 64'(busy[5]), 64'd0);
        alu_valid = 1'b1; alu_rd = 6; alu_data = 64'h66;
        push(6, 64'h66);
        @(negedge clk); alu_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t2_busy_drained", 64'(busy), 64'd0);

        // T4: x0 is never busy and its writeback is swallowed
        do_issue(0, 0, 0, 1'b1);
        #1 chk("t4_stall", 64'(issue_stall), 64'd0);
        @(negedge clk); issue_valid = 1'b0;
        #1 chk("t4_busy", 64'(busy), 64'd0);
        lsu_valid = 1'b1; lsu_rd = 0; lsu_data = 64'hDEAD;
        #1 chk("t4_lsu_ready", 64'(lsu_ready), 64'd1);
        @(negedge clk); lsu_valid = 1'b0;
        #1 chk("t4_rd_write", 64'(rd_write), 64'd0);
        chk("t4_wb_err", 64'(wb_err), 64'd0);

        // T6: spurious writeback to a non-busy register
        @(negedge clk); lsu_valid = 1'b1; lsu_rd = 9; lsu_data = 64'h9999;
        #1 chk("t6_lsu_ready", 64'(lsu_ready), 64'd1);
        chk("t6_wb_err_pre", 64'(wb_err), 64'd0);
        push(9, 64'h9999);
        @(negedge clk); lsu_valid = 1'b0;
        #1 chk("t6_wb_err_set", 64'(wb_err), 64'd1);
        chk("t6_rd_write", 64'(rd_write), 64'd1);
        repeat (3) @(negedge clk);
        chk("t6_wb_err_sticky", 64'(wb_err), 64'd1);

        // T5: busy set and clear of reg 7 on the same edge; set wins
        @(negedge clk); alu_valid = 1'b1; alu_rd = 7; alu_data = 64'h7777;
        #1 chk("t5_alu_ready", 64'(alu_ready), 64'd1);
        push(7, 64'h7777);
        @(negedge clk); alu_valid = 1'b0; do_issue(0, 0, 7, 1'b1);
        #1 chk("t5_stall", 64'(issue_stall), 64'd0);
        chk("t5_rd_write", 64'(rd_write), 64'd1);
        chk("t5_busy7_pre", 64'(busy[7]), 64'd0);
        @(negedge clk); issue_valid = 1'b0;
        #1 chk("t5_busy7_post", 64'(busy[7]), 64'd1);
        repeat (2) @(negedge clk);
        chk("t5_busy7_hold", 64'(busy[7]), 64'd1);
        alu_valid = 1'b1; alu_rd = 7; alu_data = 64'h7070;
        push(7, 64'h7070);
        @(negedge clk); alu_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_wb_err", 64'(wb_err), 64'd1);
        chk("end_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
